// File: rtl/pipe_memory_pkg.sv
// Shared types and constants for the pipe memory responder: FSM encoding,
// legal byte-lane masks and the access-width decode of a mask.
package pipe_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2,
        WIDTH_NONE = 2'd3
    } width_e;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    // Any mask outside the seven legal patterns decodes to WIDTH_NONE.
    function automatic width_e mask_width(input logic [3:0] mask);
        case (mask)
            MASK_B0, MASK_B1, MASK_B2, MASK_B3: mask_width = WIDTH_BYTE;
            MASK_H0, MASK_H1:                   mask_width = WIDTH_HALF;
            MASK_W:                             mask_width = WIDTH_WORD;
            default:                            mask_width = WIDTH_NONE;
        endcase
    endfunction

    function automatic logic [1:0] mask_offset(input logic [3:0] mask);
        case (mask)
            MASK_B1:          mask_offset = 2'd1;
            MASK_B2, MASK_H1: mask_offset = 2'd2;
            MASK_B3:          mask_offset = 2'd3;
            default:          mask_offset = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_memory_responder_if.sv
// Core-side request/response and local memory bus signals of the responder.
interface pipe_memory_responder_if;

    logic        coreEnable;
    logic        coreWriteEnable;
    logic [3:0]  coreByteSelect;
    logic [31:0] coreAddress;
    logic [31:0] coreWriteData;
    logic        coreLoadSigned;
    logic        coreBusy;
    logic [31:0] coreReadData;
    logic        coreReadDataValid;
    logic        coreAccessFault;
    logic        memReq;
    logic        memWriteEnable;
    logic [3:0]  memByteSelect;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memAck;
    logic [31:0] memReadData;
    logic        memError;

    modport slave (
        input  coreEnable, coreWriteEnable, coreByteSelect, coreAddress,
               coreWriteData, coreLoadSigned, memAck, memReadData, memError,
        output coreBusy, coreReadData, coreReadDataValid, coreAccessFault,
               memReq, memWriteEnable, memByteSelect, memAddress, memWriteData
    );

    modport master (
        output coreEnable, coreWriteEnable, coreByteSelect, coreAddress,
               coreWriteData, coreLoadSigned, memAck, memReadData, memError,
        input  coreBusy, coreReadData, coreReadDataValid, coreAccessFault,
               memReq, memWriteEnable, memByteSelect, memAddress, memWriteData
    );

endinterface

// File: rtl/pipe_memory_responder_align.sv
// Shifts raw bus read data down to bit 0 according to the lane mask and
// sign/zero-extends byte and half loads; also reports whether the mask is legal.
module load_data_align
    import pipe_memory_pkg::*;
(
    input  logic [31:0] memReadData,
    input  logic [3:0]  byteSelect,
    input  logic        loadSigned,
    output logic [31:0] alignedData,
    output logic        maskLegal
);

    width_e      width_s;
    logic [31:0] shifted_s;

    // Lane shift followed by width-dependent extension.
    always_comb begin
        width_s     = mask_width(byteSelect);
        shifted_s   = memReadData >> {mask_offset(byteSelect), 3'b000};
        alignedData = 32'h0000_0000;
        case (width_s)
            WIDTH_BYTE: alignedData = {{24{loadSigned & shifted_s[7]}}, shifted_s[7:0]};
            WIDTH_HALF: alignedData = {{16{loadSigned & shifted_s[15]}}, shifted_s[15:0]};
            WIDTH_WORD: alignedData = shifted_s;
            default:    alignedData = 32'h0000_0000;
        endcase
    end

    assign maskLegal = (width_s != WIDTH_NONE);

endmodule

// File: rtl/pipe_memory_responder.sv
// Single-outstanding load/store responder: latches a pipe request, runs one
// req/ack bus transfer with timeout, and returns aligned load data or a fault.
module pipe_memory_responder
    import pipe_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
)(
    input  logic                    clk,
    input  logic                    rst,
    pipe_memory_responder_if.slave  bus
);

    localparam logic                     TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     we_q, we_d;
    logic [3:0]               sel_q, sel_d;
    logic [31:0]              addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic                     signed_q, signed_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     fault_q, fault_d;

    logic [3:0]               align_sel_s;
    logic [31:0]              aligned_s;
    logic                     mask_legal_s;

    // In IDLE the aligner only judges the incoming mask; later it sees the latched one.
    assign align_sel_s = (state_q == ST_IDLE) ? bus.coreByteSelect : sel_q;

    load_data_align u_align (
        .memReadData (bus.memReadData),
        .byteSelect  (align_sel_s),
        .loadSigned  (signed_q),
        .alignedData (aligned_s),
        .maskLegal   (mask_legal_s)
    );

    // Next-state, request capture, completion data and timeout counting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        signed_d = signed_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.coreEnable) begin
                    we_d     = bus.coreWriteEnable;
                    sel_d    = bus.coreByteSelect;
                    addr_d   = bus.coreAddress;
                    wdata_d  = bus.coreWriteData;
                    signed_d = bus.coreLoadSigned;
                    rdata_d  = 32'h0000_0000;
                    cnt_d    = '0;
                    if (mask_legal_s) begin
                        fault_d = 1'b0;
                        state_d = ST_REQUEST;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (bus.memAck) begin
                    fault_d = bus.memError;
                    rdata_d = (we_q || bus.memError) ? 32'h0000_0000 : aligned_s;
                    state_d = ST_DONE;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    fault_d = 1'b1;
                    rdata_d = 32'h0000_0000;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request/response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'b0000;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            signed_q <= 1'b0;
            rdata_q  <= 32'h0000_0000;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            signed_q <= signed_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Busy is gated by reset so every output reads 0 while reset is held.
    assign bus.coreBusy          = ~rst & ((state_q == ST_REQUEST) ||
                                           ((state_q == ST_IDLE) && bus.coreEnable));
    assign bus.coreReadDataValid = (state_q == ST_DONE);
    assign bus.coreReadData      = (state_q == ST_DONE) ? rdata_q : 32'h0000_0000;
    assign bus.coreAccessFault   = (state_q == ST_DONE) & fault_q;

    assign bus.memReq            = (state_q == ST_REQUEST);
    assign bus.memWriteEnable    = we_q;
    assign bus.memByteSelect     = sel_q;
    assign bus.memAddress        = addr_q;
    assign bus.memWriteData      = wdata_q;

endmodule

// File: tb/tb_pipe_memory_responder.sv
// Directed self-checking bench for pipe_memory_responder (timeout set to 4 cycles).
module tb_pipe_memory_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    pipe_memory_responder_if bus();

    pipe_memory_responder #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.coreEnable      = 1'b0;
        bus.coreWriteEnable = 1'b0;
        bus.coreByteSelect  = 4'b0000;
        bus.coreAddress     = 32'h0;
        bus.coreWriteData   = 32'h0;
        bus.coreLoadSigned  = 1'b0;
        bus.memAck          = 1'b0;
        bus.memReadData     = 32'h0;
        bus.memError        = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic sgn);
        bus.coreEnable      = 1'b1;
        bus.coreWriteEnable = we;
        bus.coreByteSelect  = sel;
        bus.coreAddress     = addr;
        bus.coreWriteData   = wdata;
        bus.coreLoadSigned  = sgn;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step(); step(); #1;
        n_cmp++; if (bus.memReq !== 1'b0) begin n_bad++; $display("FAIL rst_memReq act=%b exp=0", bus.memReq); end
        n_cmp++; if (bus.coreBusy !== 1'b0) begin n_bad++; $display("FAIL rst_busy act=%b exp=0", bus.coreBusy); end
        n_cmp++; if (bus.coreReadDataValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid act=%b exp=0", bus.coreReadDataValid); end
        n_cmp++; if (bus.coreReadData !== 32'h0) begin n_bad++; $display("FAIL rst_rdata act=%h exp=0", bus.coreReadData); end
        n_cmp++; if (bus.memAddress !== 32'h0) begin n_bad++; $display("FAIL rst_addr act=%h exp=0", bus.memAddress); end
        rst = 1'b0;
        step(); #1;
        n_cmp++; if (bus.coreBusy !== 1'b0) begin n_bad++; $display("FAIL idle_busy act=%b exp=0", bus.coreBusy); end
    endtask

    task automatic test_load_word();
        step(); drive_req(1'b0, 4'b1111, 32'h100, 32'h0, 1'b0); #1;
        n_cmp++; if (bus.coreBusy !== 1'b1) begin n_bad++; $display("FAIL lw_busy_T act=%b exp=1", bus.coreBusy); end
        n_cmp++; if (bus.memReq !== 1'b0) begin n_bad++; $display("FAIL lw_req_T act=%b exp=0", bus.memReq); end
        step(); bus.memAck = 1'b1; bus.memReadData = 32'hDEADBEEF; #1;
        n_cmp++; if (bus.memReq !== 1'b1) begin n_bad++; $display("FAIL lw_req_T1 act=%b exp=1", bus.memReq); end
        n_cmp++; if (bus.coreBusy !== 1'b1) begin n_bad++; $display("FAIL lw_busy_T1 act=%b exp=1", bus.coreBusy); end
        n_cmp++; if (bus.memAddress !== 32'h100) begin n_bad++; $display("FAIL lw_addr act=%h exp=00000100", bus.memAddress); end
        n_cmp++; if (bus.memByteSelect !== 4'b1111) begin n_bad++; $display("FAIL lw_sel act=%b exp=1111", bus.memByteSelect); end
        n_cmp++; if (bus.memWriteEnable !== 1'b0) begin n_bad++; $display("FAIL lw_we act=%b exp=0", bus.memWriteEnable); end
        step(); clear_inputs(); #1;
        n_cmp++; if (bus.coreReadDataValid !== 1'b1) begin n_bad++; $display("FAIL lw_valid act=%b exp=1", bus.coreReadDataValid); end
        n_cmp++; if (bus.coreReadData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata act=%h exp=deadbeef", bus.coreReadData); end
        n_cmp++; if (bus.coreAccessFault !== 1'b0) begin n_bad++; $display("FAIL lw_fault act=%b exp=0", bus.coreAccessFault); end
        n_cmp++; if (bus.coreBusy !== 1'b0) begin n_bad++; $display("FAIL lw_busy_T2 act=%b exp=0", bus.coreBusy); end
        n_cmp++; if (bus.memReq !== 1'b0) begin n_bad++; $display("FAIL lw_req_T2 act=%b exp=0", bus.memReq); end
        step(); #1;
        n_cmp++; if (bus.coreReadDataValid !== 1'b0) begin n_bad++; $display("FAIL lw_valid_T3 act=%b exp=0", bus.coreReadDataValid); end
    endtask

    task automatic test_signed_byte();
        logic        sgn_v [2]  = '{1'b1, 1'b0};
        logic [31:0] exp_v [2]  = '{32'hFFFFFF80, 32'h00000080};
        for (int i = 0; i < 2; i++) begin
            step(); drive_req(1'b0, 4'b0100, 32'h104, 32'h0, sgn_v[i]);
            step(); bus.memAck = 1'b1; bus.memReadData = 32'h0080_0000;
            step(); clear_inputs(); #1;
            n_cmp++; if (bus.coreReadDataValid !== 1'b1) begin n_bad++; $display("FAIL sb%0d_valid act=%b exp=1", i, bus.coreReadDataValid); end
            n_cmp++; if (bus.coreReadData !== exp_v[i]) begin n_bad++; $display("FAIL sb%0d_rdata act=%h exp=%h", i, bus.coreReadData, exp_v[i]); end
        end
    endtask

    task automatic test_half_wait();
        step(); drive_req(1'b0, 4'b1100, 32'h108, 32'h0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            step(); #1;
            n_cmp++; if (bus.memReq !== 1'b1 || bus.memAddress !== 32'h108 || bus.memByteSelect !== 4'b1100)
                begin n_bad++; $display("FAIL hw_stable_T%0d act=%b/%h/%b exp=1/00000108/1100", c, bus.memReq, bus.memAddress, bus.memByteSelect); end
            n_cmp++; if (bus.coreReadDataValid !== 1'b0) begin n_bad++; $display("FAIL hw_early_valid_T%0d act=%b exp=0", c, bus.coreReadDataValid); end
        end
        step(); bus.memAck = 1'b1; bus.memReadData = 32'h8001_1234; #1;
        n_cmp++; if (bus.memReq !== 1'b1) begin n_bad++; $display("FAIL hw_req_T4 act=%b exp=1", bus.memReq); end
        step(); clear_inputs(); #1;
        n_cmp++; if (bus.coreReadDataValid !== 1'b1) begin n_bad++; $display("FAIL hw_valid_T5 act=%b exp=1", bus.coreReadDataValid); end
        n_cmp++; if (bus.coreReadData !== 32'hFFFF8001) begin n_bad++; $display("FAIL hw_rdata act=%h exp=ffff8001", bus.coreReadData); end
        n_cmp++; if (bus.coreAccessFault !== 1'b0) begin n_bad++; $display("FAIL hw_fault act=%b exp=0", bus.coreAccessFault); end
    endtask

    task automatic test_store_error();
        step(); drive_req(1'b1, 4'b0011, 32'h200, 32'h0000_ABCD, 1'b0);
        step(); bus.memAck = 1'b1; bus.memError = 1'b1; bus.memReadData = 32'h1234_5678; #1;
        n_cmp++; if (bus.memWriteEnable !== 1'b1) begin n_bad++; $display("FAIL st_we act=%b exp=1", bus.memWriteEnable); end
        n_cmp++; if (bus.memByteSelect !== 4'b0011) begin n_bad++; $display("FAIL st_sel act=%b exp=0011", bus.memByteSelect); end
        n_cmp++; if (bus.memWriteData !== 32'h0000_ABCD) begin n_bad++; $display("FAIL st_wdata act=%h exp=0000abcd", bus.memWriteData); end
        n_cmp++; if (bus.memAddress !== 32'h200) begin n_bad++; $display("FAIL st_addr act=%h exp=00000200", bus.memAddress); end
        step(); clear_inputs(); #1;
        n_cmp++; if (bus.coreReadDataValid !== 1'b1) begin n_bad++; $display("FAIL st_valid act=%b exp=1", bus.coreReadDataValid); end
        n_cmp++; if (bus.coreReadData !== 32'h0) begin n_bad++; $display("FAIL st_rdata act=%h exp=0", bus.coreReadData); end
        n_cmp++; if (bus.coreAccessFault !== 1'b1) begin n_bad++; $display("FAIL st_fault act=%b exp=1", bus.coreAccessFault); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int done_at    = -1;
        step(); drive_req(1'b0, 4'b1111, 32'h300, 32'h0, 1'b0);
        for (int c = 1; c <= 10 && done_at < 0; c++) begin
            step(); #1;
            if (bus.memReq === 1'b1) req_cycles++;
            if (bus.coreReadDataValid === 1'b1) begin
                done_at = c;
                n_cmp++; if (bus.coreAccessFault !== 1'b1) begin n_bad++; $display("FAIL to_fault act=%b exp=1", bus.coreAccessFault); end
                n_cmp++; if (bus.coreReadData !== 32'h0) begin n_bad++; $display("FAIL to_rdata act=%h exp=0", bus.coreReadData); end
                n_cmp++; if (bus.memReq !== 1'b0) begin n_bad++; $display("FAIL to_req_done act=%b exp=0", bus.memReq); end
                clear_inputs();
            end
        end
        clear_inputs();
        n_cmp++; if (req_cycles != 4) begin n_bad++; $display("FAIL to_req_cycles act=%0d exp=4", req_cycles); end
        n_cmp++; if (done_at != 5) begin n_bad++; $display("FAIL to_done_cycle act=%0d exp=5", done_at); end
    endtask

    task automatic test_illegal_mask();
        int req_seen = 0;
        step(); drive_req(1'b0, 4'b0101, 32'h400, 32'h0, 1'b0); #1;
        if (bus.memReq === 1'b1) req_seen++;
        step(); #1;
        if (bus.memReq === 1'b1) req_seen++;
        n_cmp++; if (bus.coreReadDataValid !== 1'b1) begin n_bad++; $display("FAIL il_valid_T1 act=%b exp=1", bus.coreReadDataValid); end
        n_cmp++; if (bus.coreAccessFault !== 1'b1) begin n_bad++; $display("FAIL il_fault act=%b exp=1", bus.coreAccessFault); end
        n_cmp++; if (bus.coreBusy !== 1'b0) begin n_bad++; $display("FAIL il_busy act=%b exp=0", bus.coreBusy); end
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            if (bus.memReq === 1'b1) req_seen++;
        end
        n_cmp++; if (req_seen != 0) begin n_bad++; $display("FAIL il_memReq_cycles act=%0d exp=0", req_seen); end
    endtask

    task automatic test_reset_mid();
        int valid_seen = 0;
        step(); drive_req(1'b0, 4'b1111, 32'h500, 32'h0, 1'b0);
        step();
        step(); #1;
        n_cmp++; if (bus.memReq !== 1'b1) begin n_bad++; $display("FAIL rm_req_before act=%b exp=1", bus.memReq); end
        rst = 1'b1; #1;
        n_cmp++; if ({bus.memReq, bus.coreBusy, bus.coreReadDataValid, bus.coreAccessFault, bus.memWriteEnable} !== 5'b0)
            begin n_bad++; $display("FAIL rm_ctrl_zero act=%b exp=00000", {bus.memReq, bus.coreBusy, bus.coreReadDataValid, bus.coreAccessFault, bus.memWriteEnable}); end
        n_cmp++; if ({bus.memAddress, bus.memWriteData, bus.coreReadData, bus.memByteSelect} !== 100'b0)
            begin n_bad++; $display("FAIL rm_data_zero act=%h/%h/%h/%b exp=0", bus.memAddress, bus.memWriteData, bus.coreReadData, bus.memByteSelect); end
        step(); clear_inputs(); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(); #1;
            if (bus.coreReadDataValid === 1'b1) valid_seen++;
        end
        n_cmp++; if (valid_seen != 0) begin n_bad++; $display("FAIL rm_no_valid act=%0d exp=0", valid_seen); end
        step(); drive_req(1'b0, 4'b0001, 32'h504, 32'h0, 1'b1);
        step(); bus.memAck = 1'b1; bus.memReadData = 32'h0000_00A5;
        step(); clear_inputs(); #1;
        n_cmp++; if (bus.coreReadDataValid !== 1'b1) begin n_bad++; $display("FAIL rm_after_valid act=%b exp=1", bus.coreReadDataValid); end
        n_cmp++; if (bus.coreReadData !== 32'hFFFFFFA5) begin n_bad++; $display("FAIL rm_after_rdata act=%h exp=ffffffa5", bus.coreReadData); end
    endtask

    task automatic test_back_to_back();
        step(); drive_req(1'b0, 4'b0010, 32'h600, 32'h0, 1'b0);
        step(); bus.memAck = 1'b1; bus.memReadData = 32'h0000_F100;
        step(); bus.memAck = 1'b0;
        drive_req(1'b0, 4'b1000, 32'h604, 32'h0, 1'b1); #1;
        n_cmp++; if (bus.coreReadData !== 32'h0000_00F1) begin n_bad++; $display("FAIL bb_rdata0 act=%h exp=000000f1", bus.coreReadData); end
        n_cmp++; if (bus.coreBusy !== 1'b0) begin n_bad++; $display("FAIL bb_busy_done act=%b exp=0", bus.coreBusy); end
        step(); #1;
        n_cmp++; if (bus.coreBusy !== 1'b1 || bus.memReq !== 1'b0) begin n_bad++; $display("FAIL bb_idle act=%b/%b exp=1/0", bus.coreBusy, bus.memReq); end
        step(); bus.memAck = 1'b1; bus.memReadData = 32'h7F00_0000; #1;
        n_cmp++; if (bus.memAddress !== 32'h604) begin n_bad++; $display("FAIL bb_addr1 act=%h exp=00000604", bus.memAddress); end
        step(); clear_inputs(); #1;
        n_cmp++; if (bus.coreReadData !== 32'h0000_007F) begin n_bad++; $display("FAIL bb_rdata1 act=%h exp=0000007f", bus.coreReadData); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_signed_byte();
        test_half_wait();
        test_store_error();
        test_timeout();
        test_illegal_mask();
        test_reset_mid();
        test_back_to_back();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_memory_responder.md
Name: pipe_memory_responder

Overview:
Memory-side responder for the load/store requests issued by the execute/operation stage. It accepts one word-aligned request with a byte select, and runs a single-outstanding req/ack transaction on the local memory bus. It stalls the pipe until completion, then returns load data shifted down to bit 0 and sign/zero-extended for writeback. It also flags bus errors and timeouts as access faults.

Parameters:
TIMEOUT_CYCLES, 255, cycles in REQUEST without memAck before a fault is forced; 0 disables the timeout
TIMEOUT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  single clock
rst  input  1  reset, asynchronous, active-high
coreEnable  input  1  request valid; held until coreBusy is low
coreWriteEnable  input  1  1=store, 0=load
coreByteSelect  input  4  lane mask; legal values are 0001/0010/0100/1000/0011/1100/1111
coreAddress  input  32  word address, bits [1:0] are 0
coreWriteData  input  32  store data, already lane-aligned
coreLoadSigned  input  1  sign-extend byte/half loads
coreBusy  output  1  stall to the pipe
coreReadData  output  32  aligned, extended load result (0 for stores)
coreReadDataValid  output  1  one-cycle completion pulse
coreAccessFault  output  1  valid with coreReadDataValid; error, timeout, or illegal mask
memReq  output  1  bus request
memWriteEnable  output  1  bus write
memByteSelect  output  4  bus lanes
memAddress  output  32  bus address
memWriteData  output  32  bus write data
memAck  input  1  transfer done; may be asserted in the first memReq cycle
memReadData  input  32  sampled when memAck is high
memError  input  1  sampled when memAck is high

Behaviour:
- Reset (async): state=IDLE, counter=0, and all outputs 0 (including the memory-side registers).
- States: IDLE, REQUEST, DONE.
- IDLE:
  - On coreEnable, register write enable, byte select, address, write data and signed flag.
  - If byteSelect is illegal, go to DONE with fault=1 and never assert memReq.
  - Otherwise go to REQUEST.
  - coreBusy = coreEnable in this state (combinational).
- REQUEST:
  - memReq=1 and mem* outputs are driven from the registers, stable until ack. coreBusy=1.
  - On memAck: capture memReadData, set fault=memError, go to DONE.
  - If no ack and TIMEOUT_CYCLES!=0 and the counter has reached TIMEOUT_CYCLES-1: fault=1, readData=0, go to DONE.
  - The counter clears on entry to REQUEST.
- DONE (one cycle):
  - coreReadDataValid=1 and coreBusy=0; coreReadData and coreAccessFault are valid.
  - Unconditionally returns to IDLE.
  - coreEnable is ignored in DONE; the next request is accepted in IDLE at the earliest.
- Minimum latency: request seen at cycle T, memReq at T+1 with ack at T+1, valid/busy-low at T+2. Each additional wait cycle adds one.
- Load alignment:
  - offset = index of the lowest set bit of the mask; result = memReadData >> (8*offset).
  - Width from the mask: 1 lane = byte, 2 = half, 4 = word.
  - Byte/half: if signed, extend from bit 7/15; otherwise zero-fill.
  - Stores or faults: coreReadData=0.
- memReq deasserts the cycle after memAck. It is never asserted twice for one request.
- Reset mid-transaction: memReq drops immediately, the transaction is abandoned, and no valid pulse is produced.

Decomposition:
- Shared package pipe_memory_pkg: state encoding (IDLE=2'd0, REQUEST=2'd1, DONE=2'd2), legal-mask constants, width codes.
- One combinational sub-module: load_data_align, with inputs (memReadData, byteSelect, loadSigned) and output alignedData, plus a maskLegal flag.
- FSM, registers and timeout counter live in the top level.

Test Plan:
- Load word, mask 1111, addr 0x100, ack in first memReq cycle, memReadData=0xDEADBEEF -> memReq at T+1 only; valid at T+2 with readData=0xDEADBEEF, fault=0; busy high for T and T+1.
- Signed byte load, mask 0100, memReadData=0x0080_0000, signed=1 -> readData=0xFFFFFF80; repeat with signed=0 -> 0x00000080.
- Half load, mask 1100, memReadData=0x8001_1234, signed=1, ack after 3 wait cycles -> readData=0xFFFF8001, valid at T+5, mem* outputs stable throughout.
- Store, mask 0011, writeData=0x0000_ABCD, addr 0x200 -> memWriteEnable=1, memByteSelect=0011, memWriteData=0xABCD; valid pulse with readData=0; memError=1 on ack -> fault=1.
- No ack with TIMEOUT_CYCLES=4 -> exactly 4 memReq cycles, then DONE with fault=1 and memReq low; illegal mask 0101 -> DONE at T+1, fault=1, memReq never high.
- Assert rst in the second REQUEST cycle -> all outputs 0 immediately, no valid pulse; the next request after reset completes normally.
